// File: rtl/io_request_responder.sv
// Board-side responder for processor I/O requests: debounced key input handshake and 8-digit hex output display.
// Optional macro IO_ECHO_EN: show the live switch value on HEX7..HEX0 while an input request waits for a key press.
module io_request_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SW_WIDTH        = 15
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                insert,
    input  logic [SW_WIDTH-1:0] SW,
    input  logic                input_flag,
    input  logic                output_flag,
    input  logic [31:0]         out_data,
    output logic [31:0]         user_input,
    output logic                in_ready,
    output logic                stall,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, ACK, WAIT_RELEASE} state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d;
    logic               db_q, db_d, db_prev_q, db_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        user_input_q, user_input_d;
    logic [31:0]        disp_q, disp_d;
    logic [31:0]        show_val;
    logic               press;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            db_prev_q    <= 1'b0;
            cnt_q        <= '0;
            user_input_q <= '0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_prev_q    <= db_prev_d;
            cnt_q        <= cnt_d;
            user_input_q <= user_input_d;
            disp_q       <= disp_d;
        end
    end

    always_comb begin
        sync1_d   = insert;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        cnt_d     = '0;
        // db flips on the cycle the DEBOUNCE_CYCLES-th consecutive differing sample is seen
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press = db_q & ~db_prev_q;

        state_d      = state_q;
        user_input_d = user_input_q;
        in_ready     = 1'b0;
        stall        = 1'b0;
        case (state_q)
            IDLE: begin
                if (input_flag) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                stall = 1'b1;
                if (!input_flag) begin
                    state_d = IDLE;
                end else if (press) begin
                    user_input_d = 32'(SW);
                    state_d      = ACK;
                end
            end
            ACK: begin
                in_ready = 1'b1;
                state_d  = db_q ? WAIT_RELEASE : IDLE;
            end
            default: begin
                // a request arriving while the key is still held must wait for a fresh press
                stall = input_flag;
                if (!db_q) state_d = IDLE;
            end
        endcase

        disp_d = output_flag ? out_data : disp_q;

`ifdef IO_ECHO_EN
        show_val = (state_q == WAIT_PRESS) ? 32'(SW) : disp_q;
`else
        show_val = disp_q;
`endif
        HEX0 = seg7(show_val[3:0]);
        HEX1 = seg7(show_val[7:4]);
        HEX2 = seg7(show_val[11:8]);
        HEX3 = seg7(show_val[15:12]);
        HEX4 = seg7(show_val[19:16]);
        HEX5 = seg7(show_val[23:20]);
        HEX6 = seg7(show_val[27:24]);
        HEX7 = seg7(show_val[31:28]);
    end

    assign user_input = user_input_q;

endmodule

// File: tb/tb_io_request_responder.sv
// Self-checking bench for io_request_responder with DEBOUNCE_CYCLES=4; expected input words kept in a scoreboard queue.
module tb_io_request_responder;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        insert = 1'b0;
    logic [14:0] SW = '0;
    logic        input_flag = 1'b0;
    logic        output_flag = 1'b0;
    logic [31:0] out_data = '0;
    logic [31:0] user_input;
    logic        in_ready, stall;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] expq[$];

    io_request_responder #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(15)) dut (
        .CLK(CLK), .reset(reset), .insert(insert), .SW(SW),
        .input_flag(input_flag), .output_flag(output_flag), .out_data(out_data),
        .user_input(user_input), .in_ready(in_ready), .stall(stall),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] exp_hex(input logic [31:0] v);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[i*7 +: 7] = glyph(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [55:0] hex_bus();
        return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Returns cycle count to in_ready (0 on timeout) and whether stall held high before it.
    task automatic wait_ready(output int k, output bit stall_ok);
        k = 0;
        stall_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                k = i;
                return;
            end
            if (!stall) stall_ok = 1'b0;
        end
    endtask

    task automatic pop_cmp(input string name);
        logic [31:0] e;
        n_chk++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: in_ready with empty scoreboard, user_input=%h", name, user_input);
        end else begin
            e = expq.pop_front();
            if (user_input !== e) begin
                n_fail++;
                $display("FAIL %s: user_input=%h expected %h", name, user_input, e);
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (user_input !== 32'h0 || stall !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: ui=%h stall=%b rdy=%b expected 0/0/0", user_input, stall, in_ready);
        end
        n_chk++;
        if (hex_bus() !== {8{7'b1000000}}) begin
            n_fail++;
            $display("FAIL reset_hex: got %h expected %h", hex_bus(), {8{7'b1000000}});
        end
        cyc(3);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_input();
        int k; bit sok;
        SW = 15'h1234;
        input_flag = 1'b1;
        cyc(1);
        #1;
        n_chk++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL input_stall: stall=%b expected 1", stall); end
        expq.push_back(32'h00001234);
        insert = 1'b1;
        wait_ready(k, sok);
        n_chk++;
        if (k != 7) begin n_fail++; $display("FAIL input_latency: %0d cycles expected 7", k); end
        n_chk++;
        if (!sok) begin n_fail++; $display("FAIL input_stall_hold: stall dropped before in_ready, expected held 1"); end
        if (k != 0) pop_cmp("input_word");
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL ack_stall: stall=%b expected 0", stall); end
        input_flag = 1'b0;
        cyc(1);
        n_chk++;
        if (in_ready !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_pulse: rdy=%b stall=%b expected 0/0", in_ready, stall);
        end
    endtask

    task automatic test_held_key();
        int k; bit sok; bit seen;
        input_flag = 1'b1;
        #1;
        n_chk++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL held_stall: stall=%b expected 1", stall); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (in_ready || !stall) seen = 1'b1;
        end
        insert = 1'b0;
        SW = 15'h7FFF;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (in_ready) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL held_no_ready: in_ready or stall drop seen=1 expected 0"); end
        n_chk++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL held_rearm: stall=%b expected 1", stall); end
        expq.push_back(32'h00007FFF);
        insert = 1'b1;
        wait_ready(k, sok);
        n_chk++;
        if (k != 7) begin n_fail++; $display("FAIL held_latency: %0d cycles expected 7", k); end
        if (k != 0) pop_cmp("held_word");
        input_flag = 1'b0;
        insert = 1'b0;
        cyc(10);
    endtask

    task automatic test_glitch();
        bit seen_rdy, seen_drop;
        input_flag = 1'b1;
        cyc(1);
        insert = 1'b1;
        cyc(3);
        insert = 1'b0;
        seen_rdy = 1'b0;
        seen_drop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (in_ready) seen_rdy = 1'b1;
            if (!stall) seen_drop = 1'b1;
        end
        n_chk++;
        if (seen_rdy || seen_drop) begin
            n_fail++;
            $display("FAIL glitch: ready_seen=%b stall_drop=%b expected 0/0", seen_rdy, seen_drop);
        end
        input_flag = 1'b0;
        cyc(1);
        n_chk++;
        if (stall !== 1'b0 || user_input !== 32'h00007FFF) begin
            n_fail++;
            $display("FAIL cancel: stall=%b ui=%h expected 0/00007fff", stall, user_input);
        end
    endtask

    task automatic test_output();
        int k; bit sok;
        logic [55:0] e;
        out_data = 32'h11111111;
        output_flag = 1'b1;
        #1;
        n_chk++;
        if (hex_bus() !== exp_hex(32'h0)) begin
            n_fail++;
            $display("FAIL out_before_edge: hex=%h expected %h", hex_bus(), exp_hex(32'h0));
        end
        cyc(1);
        out_data = 32'h89ABCDEF;
        cyc(1);
        output_flag = 1'b0;
        out_data = 32'h0;
        n_chk++;
        if (hex_bus() !== exp_hex(32'h89ABCDEF)) begin
            n_fail++;
            $display("FAIL out_last_wins: hex=%h expected %h", hex_bus(), exp_hex(32'h89ABCDEF));
        end
        SW = 15'h0055;
        input_flag = 1'b1;
        out_data = 32'hDEADBEEF;
        output_flag = 1'b1;
        cyc(1);
        output_flag = 1'b0;
`ifdef IO_ECHO_EN
        e = exp_hex(32'h00000055);
`else
        e = exp_hex(32'hDEADBEEF);
`endif
        n_chk++;
        if (hex_bus() !== e || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL out_concurrent: hex=%h stall=%b expected %h/1", hex_bus(), stall, e);
        end
        expq.push_back(32'h00000055);
        insert = 1'b1;
        wait_ready(k, sok);
        n_chk++;
        if (k != 7) begin n_fail++; $display("FAIL out_input_latency: %0d cycles expected 7", k); end
        if (k != 0) pop_cmp("out_input_word");
        n_chk++;
        if (hex_bus() !== exp_hex(32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL out_deadbeef: hex=%h expected %h", hex_bus(), exp_hex(32'hDEADBEEF));
        end
        input_flag = 1'b0;
        insert = 1'b0;
        cyc(10);
    endtask

    task automatic test_echo();
        int k; bit sok;
        logic [55:0] e;
        SW = 15'h00AB;
        input_flag = 1'b1;
        cyc(1);
`ifdef IO_ECHO_EN
        e = exp_hex(32'h000000AB);
`else
        e = exp_hex(32'hDEADBEEF);
`endif
        n_chk++;
        if (hex_bus() !== e) begin
            n_fail++;
            $display("FAIL echo_wait: hex=%h expected %h", hex_bus(), e);
        end
        expq.push_back(32'h000000AB);
        insert = 1'b1;
        wait_ready(k, sok);
        n_chk++;
        if (k != 7) begin n_fail++; $display("FAIL echo_latency: %0d cycles expected 7", k); end
        if (k != 0) pop_cmp("echo_word");
        n_chk++;
        if (hex_bus() !== exp_hex(32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL echo_restore: hex=%h expected %h", hex_bus(), exp_hex(32'hDEADBEEF));
        end
        input_flag = 1'b0;
        insert = 1'b0;
        cyc(10);
    endtask

    task automatic test_reset_mid();
        input_flag = 1'b1;
        cyc(2);
        n_chk++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: stall=%b expected 1", stall); end
        @(posedge CLK);
        #3 reset = 1'b1;
        #1;
        n_chk++;
        if (user_input !== 32'h0 || stall !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outs: ui=%h stall=%b rdy=%b expected 0/0/0", user_input, stall, in_ready);
        end
        n_chk++;
        if (hex_bus() !== {8{7'b1000000}}) begin
            n_fail++;
            $display("FAIL mid_reset_hex: got %h expected %h", hex_bus(), {8{7'b1000000}});
        end
        input_flag = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_input();
        test_held_key();
        test_glitch();
        test_output();
        test_echo();
        test_reset_mid();
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_request_responder.md
Name: io_request_responder

Overview:
- Board-side responder to the processor's I/O requests.
- Services input requests (input_flag): stalls the core until the operator presses the debounced insert key, then returns the switch value on user_input.
- Services output requests (output_flag): latches the 32-bit value and shows it as 8 hex digits on HEX7..HEX0.
- Sits between the processor datapath and the DE2 switches, key and seven-segment displays.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced insert level changes.
- SW_WIDTH, 15: switch bus width; the value is zero-extended to 32 bits.

Ports:
- CLK  in  1: system clock, the single clock domain.
- reset  in  1: asynchronous, active-high; clears all state.
- insert  in  1: raw push-button level, active-high, asynchronous to CLK.
- SW  in  SW_WIDTH: raw switch values.
- input_flag  in  1: processor requests an input word; held high until in_ready.
- output_flag  in  1: processor presents an output word this cycle.
- out_data  in  32: value to display; valid when output_flag=1.
- user_input  out  32: last accepted input word, {zeros, SW}.
- in_ready  out  1: one-cycle pulse; user_input is valid and the core may advance.
- stall  out  1: high while an input request waits for a key press.
- HEX0..HEX7  out  7 each: active-low segments {g,f,e,d,c,b,a}; HEX0 shows the lowest nibble.

Behaviour:
- Reset values:
  - user_input=0, in_ready=0, stall=0, display register=0.
  - All HEX outputs 7'b1000000 ("0").
  - Synchronizer, debounce counter and debounced level all 0; FSM in IDLE.
- Insert synchronizer:
  - 2-flop synchronizer on insert.
  - The debounced level db toggles only after the synced value differs from db for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears on any cycle where synced==db.
  - A press is the rising edge of db. Raw-to-edge latency is 2+DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are never seen.
- Input FSM states: IDLE, WAIT_PRESS, ACK, WAIT_RELEASE.
  - IDLE: stall=0. input_flag=1 -> WAIT_PRESS. Presses arriving in IDLE are ignored.
  - WAIT_PRESS: stall=1 combinationally.
    - On a press edge: latch user_input <= {zero-ext SW}, sampled in the edge cycle, then go to ACK.
    - If input_flag drops (cancel): return to IDLE; user_input unchanged.
  - ACK: in_ready=1 for exactly one cycle, stall=0.
    - If db is already low -> IDLE, else -> WAIT_RELEASE.
  - WAIT_RELEASE: stall=0. Wait for db=0 -> IDLE. One held press satisfies at most one request.
    - input_flag=1 here is accepted but held (stall=1) until release; the FSM then goes via IDLE to WAIT_PRESS.
- Output path:
  - output_flag=1 at a rising edge -> display register <= out_data. Visible on HEX the following cycle; HEX decode is combinational from the register.
  - Back-to-back output_flag cycles: the last value wins.
- Simultaneous input_flag and output_flag: both serviced independently in the same cycle.
- Hex decode: standard 0-F glyphs; A-F shown as A, b, C, d, E, F.
- Reset mid-request: FSM to IDLE, stall drops asynchronously, display cleared.

Optional Feature:
- Macro IO_ECHO_EN.
- Defined: while the FSM is in WAIT_PRESS, HEX7..HEX0 show the live zero-extended SW value (operator preview). Display-register contents are shown otherwise; the register itself is not modified.
- Undefined: HEX always shows the display register.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert reset mid-cycle -> immediately user_input=0, stall=0, in_ready=0, all HEX=7'b1000000.
- Input request: input_flag=1, SW=15'h1234, insert high held 10 cycles -> stall=1 until press; one in_ready pulse at cycle 2+4+1 after insert rises; user_input=32'h00001234; stall=0 afterwards.
- Glitch rejection: in WAIT_PRESS, insert high for 3 cycles then low -> no in_ready, stall stays 1.
- Held key: after the ACK above, keep insert high and raise input_flag again -> stall=1, no new in_ready until insert released ≥4 cycles and pressed again; second SW=15'h7FFF gives user_input=32'h00007FFF.
- Output: output_flag=1, out_data=32'hDEADBEEF for one cycle -> next cycle HEX7..HEX0 show d,E,A,d,b,E,E,F; concurrent input request still completes normally.
- IO_ECHO_EN: in WAIT_PRESS with SW=15'h00AB -> HEX1/HEX0 show A/b, others "0"; after ACK, HEX returns to the prior display value.
